// File: rtl/hiscore_engine.sv
// High-score manager: captures an address table and a score image over ioctl, waits
// for every table entry's start/end markers in game RAM, then writes the image back.
module hiscore_engine #(
  parameter int ENTRIES    = 16,
  parameter int RAM_AW     = 10,
  parameter int BUF_AW     = 8,
  parameter int CFG_INDEX  = 3,
  parameter int DATA_INDEX = 4,
  parameter int CHECK_GAP  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [7:0]        ioctl_din,
  output logic [RAM_AW-1:0] ram_address,
  output logic [7:0]        ram_data_out,
  output logic              ram_we,
  output logic              ram_access,
  input  logic [7:0]        ram_data_in,
  output logic              hs_inserted
);
  localparam int EW = $clog2(ENTRIES);
  localparam int NW = EW + 1;

  typedef enum logic [2:0] {IDLE, CHK_S, WAIT_S, CHK_E, WAIT_E, GAP, WRITE, DONE} state_t;

  logic [RAM_AW-1:0] base_mem [ENTRIES];
  logic [7:0]        len_mem  [ENTRIES];
  logic [7:0]        smk_mem  [ENTRIES];
  logic [7:0]        emk_mem  [ENTRIES];
  logic [7:0]        buf_mem  [2**BUF_AW];

  state_t            state_q, state_d;
  logic [NW-1:0]     e_q, e_d, num_q, num_d, u_q, u_d;
  logic [7:0]        k_q, k_d, o_q, o_d;
  logic [BUF_AW-1:0] p_q, p_d;
  logic [15:0]       gap_q, gap_d;
  logic [24:0]       upaddr_q, upaddr_d;
  logic              dl_q, dl_d, img_valid_q, img_valid_d, past_q, past_d, upl_q, upl_d;
  logic [RAM_AW-1:0] ram_address_q, ram_address_d;
  logic [7:0]        ram_data_out_q, ram_data_out_d;
  logic              ram_we_q, ram_we_d, ram_access_q, ram_access_d, hs_q, hs_d;

  logic [21:0]       rec_s;
  logic              rec_ok_s, cfg_wr_s, data_wr_s, new_dl_s;
  logic [31:0]       base32_s;
  logic [NW-1:0]     e_nx_s;
  logic [RAM_AW-1:0] base_e_s, base_nx_s;
  logic [7:0]        len_e_s, smk_e_s, emk_e_s, len_u_s;

  assign rec_s     = ioctl_addr[24:3];
  assign rec_ok_s  = rec_s < 22'(ENTRIES);
  assign cfg_wr_s  = ioctl_download && ioctl_wr && (ioctl_index == 8'(CFG_INDEX));
  assign data_wr_s = ioctl_download && ioctl_wr && (ioctl_index == 8'(DATA_INDEX));
  assign new_dl_s  = ioctl_download &&
                     ((ioctl_index == 8'(CFG_INDEX)) || (ioctl_index == 8'(DATA_INDEX)));

  assign e_nx_s    = e_q + NW'(1);
  assign base_e_s  = base_mem[e_q[EW-1:0]];
  assign base_nx_s = base_mem[e_nx_s[EW-1:0]];
  assign len_e_s   = len_mem[e_q[EW-1:0]];
  assign smk_e_s   = smk_mem[e_q[EW-1:0]];
  assign emk_e_s   = emk_mem[e_q[EW-1:0]];
  assign len_u_s   = len_mem[u_q[EW-1:0]];

  // Big-endian address byte merged into the stored base; only the low RAM_AW bits survive.
  always_comb begin
    base32_s = 32'(base_mem[rec_s[EW-1:0]]);
    case (ioctl_addr[1:0])
      2'd0:    base32_s[31:24] = ioctl_dout;
      2'd1:    base32_s[23:16] = ioctl_dout;
      2'd2:    base32_s[15:8]  = ioctl_dout;
      default: base32_s[7:0]   = ioctl_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_s && rec_ok_s) begin
      case (ioctl_addr[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: base_mem[rec_s[EW-1:0]] <= base32_s[RAM_AW-1:0];
        3'd4:    len_mem[rec_s[EW-1:0]] <= ioctl_dout;
        3'd5:    smk_mem[rec_s[EW-1:0]] <= ioctl_dout;
        3'd6:    emk_mem[rec_s[EW-1:0]] <= ioctl_dout;
        default: ;
      endcase
    end
    if (data_wr_s) buf_mem[ioctl_addr[BUF_AW-1:0]] <= ioctl_dout;
  end

  always_comb begin
    state_d = state_q;  e_d = e_q;  k_d = k_q;  p_d = p_q;  gap_d = gap_q;
    u_d = u_q;  o_d = o_q;  upaddr_d = upaddr_q;  upl_d = ioctl_upload;  dl_d = ioctl_download;
    num_d = num_q;  img_valid_d = img_valid_q;
    ram_address_d = ram_address_q;  ram_data_out_d = ram_data_out_q;  ram_we_d = 1'b0;

    if (cfg_wr_s && (ioctl_addr == 25'd0)) num_d = '0;
    if (cfg_wr_s && rec_ok_s && (ioctl_addr[2:0] == 3'd7)) num_d = {1'b0, rec_s[EW-1:0]} + NW'(1);
    if (data_wr_s) img_valid_d = 1'b1;

    if (new_dl_s) begin
      state_d = IDLE;
    end else if (ioctl_upload) begin
      // Upload owns the RAM port; the FSM stays frozen in whatever state it was in.
      upaddr_d = ioctl_addr;
      if (ioctl_addr == 25'd0) begin
        u_d = '0;
        o_d = 8'd0;
      end else if ((ioctl_addr != upaddr_q) && (u_q < num_q)) begin
        if ((len_u_s == 8'd0) || (o_q == len_u_s - 8'd1)) begin
          u_d = u_q + NW'(1);
          o_d = 8'd0;
        end else begin
          o_d = o_q + 8'd1;
        end
      end
      ram_address_d = base_mem[u_d[EW-1:0]] + RAM_AW'(o_d);
    end else begin
      case (state_q)
        IDLE: begin
          if ((num_q != '0) && img_valid_q && !ioctl_download && !dl_q) begin
            e_d = '0;
            ram_address_d = base_mem[0];
            state_d = CHK_S;
          end
        end
        CHK_S: begin
          if (len_e_s != 8'd0) begin
            state_d = WAIT_S;
          end else if (e_nx_s == num_q) begin
            e_d = '0;  k_d = 8'd0;  p_d = '0;
            state_d = WRITE;
          end else begin
            e_d = e_nx_s;
            ram_address_d = base_nx_s;
          end
        end
        WAIT_S: begin
          if (ram_data_in != smk_e_s) begin
            gap_d = 16'd0;
            state_d = GAP;
          end else begin
            ram_address_d = base_e_s + RAM_AW'(len_e_s) - RAM_AW'(1);
            state_d = CHK_E;
          end
        end
        CHK_E: state_d = WAIT_E;
        WAIT_E: begin
          if (ram_data_in != emk_e_s) begin
            gap_d = 16'd0;
            state_d = GAP;
          end else if (e_nx_s == num_q) begin
            e_d = '0;  k_d = 8'd0;  p_d = '0;
            state_d = WRITE;
          end else begin
            e_d = e_nx_s;
            ram_address_d = base_nx_s;
            state_d = CHK_S;
          end
        end
        GAP: begin
          if (gap_q == 16'(CHECK_GAP - 1)) begin
            e_d = '0;
            ram_address_d = base_mem[0];
            state_d = CHK_S;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        WRITE: begin
          if (len_e_s != 8'd0) begin
            ram_we_d       = 1'b1;
            ram_address_d  = base_e_s + RAM_AW'(k_q);
            ram_data_out_d = buf_mem[p_q];
            p_d            = p_q + BUF_AW'(1);
          end
          if ((len_e_s == 8'd0) || (k_q == len_e_s - 8'd1)) begin
            k_d = 8'd0;
            if (e_nx_s == num_q) state_d = DONE;
            else                 e_d = e_nx_s;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    past_d       = (u_d >= num_q);
    ram_access_d = ioctl_upload || ram_we_d ||
                   (state_d inside {CHK_S, WAIT_S, CHK_E, WAIT_E, WRITE});
    hs_d         = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  e_q <= '0;  k_q <= 8'd0;  p_q <= '0;  gap_q <= 16'd0;
      u_q <= '0;  o_q <= 8'd0;  upaddr_q <= 25'd0;  upl_q <= 1'b0;  dl_q <= 1'b0;
      num_q <= '0;  img_valid_q <= 1'b0;  past_q <= 1'b0;
      ram_address_q <= '0;  ram_data_out_q <= 8'd0;  ram_we_q <= 1'b0;
      ram_access_q <= 1'b0;  hs_q <= 1'b0;
    end else begin
      state_q <= state_d;  e_q <= e_d;  k_q <= k_d;  p_q <= p_d;  gap_q <= gap_d;
      u_q <= u_d;  o_q <= o_d;  upaddr_q <= upaddr_d;  upl_q <= upl_d;  dl_q <= dl_d;
      num_q <= num_d;  img_valid_q <= img_valid_d;  past_q <= past_d;
      ram_address_q <= ram_address_d;  ram_data_out_q <= ram_data_out_d;  ram_we_q <= ram_we_d;
      ram_access_q <= ram_access_d;  hs_q <= hs_d;
    end
  end

  // Upload data comes straight from RAM so it is ready two cycles after an address change.
  assign ioctl_din    = (upl_q && !past_q) ? ram_data_in : 8'h00;
  assign ram_address  = ram_address_q;
  assign ram_data_out = ram_data_out_q;
  assign ram_we       = ram_we_q;
  assign ram_access   = ram_access_q;
  assign hs_inserted  = hs_q;

endmodule

// File: tb/tb_hiscore_engine.sv
// Self-checking bench for hiscore_engine: behavioural game RAM, write scoreboard,
// table-driven upload vectors and hand-written marker/reset corner cases.
module tb_hiscore_engine;
  localparam int GAP = 40;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0, ioctl_index = 8'd0;
  logic [7:0]  ioctl_din, ram_data_out, ram_data_in;
  logic [9:0]  ram_address;
  logic        ram_we, ram_access, hs_inserted;

  always #5 clk = ~clk;

  hiscore_engine #(.CHECK_GAP(GAP)) dut (
    .clk(clk), .reset(rst), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_din(ioctl_din), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_we(ram_we), .ram_access(ram_access),
    .ram_data_in(ram_data_in), .hs_inserted(hs_inserted)
  );

  // Game RAM model: synchronous read, one cycle of latency.
  logic [7:0] mem [1024];
  logic       poke_en = 1'b0, clr_en = 1'b0;
  logic [9:0] poke_a = 10'd0;
  logic [7:0] poke_d = 8'd0;
  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      if (ram_we) mem[ram_address] <= ram_data_out;
      if (poke_en) mem[poke_a] <= poke_d;
    end
    ram_data_in <= mem[ram_address];
  end

  typedef struct packed {logic [9:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [24:0] addr; logic [7:0] din;} up_vec_t;
  wr_t exp_q[$];
  int  n_pass = 0, n_total = 0, wr_cnt = 0;
  int  bursts = 0, zrun = 0, gap_seen = 0;
  logic gap_mon = 1'b0, ra_prev = 1'b0, end_rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] img_b(input int s, input int i);
    return 8'((s * 37 + i * 11 + 5) & 255);
  endfunction

  // Write scoreboard and RAM-access observers.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_address, ram_data_out);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write_addr", 32'(ram_address), 32'(w.a));
          chk("write_data", 32'(ram_data_out), 32'(w.d));
        end
      end
      if (ram_access && !ram_we && ram_address == 10'h001) end_rd_seen = 1'b1;
      if (gap_mon) begin
        if (ram_access) begin
          if (!ra_prev) begin bursts++; gap_seen = zrun; end
          zrun = 0;
        end else zrun++;
      end
      ra_prev = ram_access;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1; tick(); poke_en = 1'b0;
  endtask
  task automatic clear_ram(); clr_en = 1'b1; tick(); clr_en = 1'b0; endtask
  task automatic push_w(input logic [9:0] a, input logic [7:0] d);
    wr_t w; w.a = a; w.d = d; exp_q.push_back(w);
  endtask
  task automatic dl_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(); ioctl_wr = 1'b0; tick();
  endtask
  task automatic dl_rec(input int n, input logic [31:0] b, input logic [7:0] len,
                        input logic [7:0] s, input logic [7:0] e);
    logic [7:0] by [8];
    by[0] = b[31:24]; by[1] = b[23:16]; by[2] = b[15:8]; by[3] = b[7:0];
    by[4] = len; by[5] = s; by[6] = e; by[7] = 8'h00;
    for (int i = 0; i < 8; i++) dl_wr(8'd3, 25'(n * 8 + i), by[i]);
  endtask
  task automatic dl_img(input int s, input int n);
    for (int i = 0; i < n; i++) dl_wr(8'd4, 25'(i), img_b(s, i));
  endtask
  task automatic dl_done(); ioctl_download = 1'b0; ioctl_addr = 25'd0; tick(); endtask
  task automatic wait_hs(input string name, input int budget);
    for (int n = 0; n < budget && !hs_inserted; n++) @(negedge clk);
    chk(name, 32'(hs_inserted), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_all_writes"}, 32'(exp_q.size()), 32'd0);
  endtask
  task automatic setup_markers(input logic [7:0] m23);
    clear_ram();
    poke(10'h00B, 8'h01); poke(10'h01A, 8'h00); poke(10'h023, m23); poke(10'h026, 8'h00);
  endtask
  task automatic push_scn1(input int s);
    for (int k = 0; k < 16; k++) push_w(10'h00B + 10'(k), img_b(s, k));
    for (int k = 0; k < 4; k++)  push_w(10'h023 + 10'(k), img_b(s, 16 + k));
  endtask
  task automatic dl_scn1_tables();
    dl_rec(0, 32'h0000000B, 8'd16, 8'h01, 8'h00);
    dl_rec(1, 32'h00000023, 8'd4, 8'h12, 8'h00);
  endtask

  initial begin
    up_vec_t uv [21];
    int wb;
    for (int i = 0; i < 20; i++) begin uv[i].addr = 25'(i); uv[i].din = img_b(1, i); end
    uv[20].addr = 25'd20; uv[20].din = 8'h00;

    clear_ram();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {22'd0, ram_we, ram_access, hs_inserted, ram_data_out},  32'd0);
    chk("reset_addr_din", {14'd0, ram_address, ioctl_din}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic insertion of two records.
    setup_markers(8'h12);
    push_scn1(1);
    dl_scn1_tables(); dl_img(1, 20); dl_done();
    wait_hs("scn1_inserted", 400);

    // Upload read-back, table driven.
    ioctl_upload = 1'b1;
    for (int i = 0; i < 21; i++) begin
      ioctl_addr = uv[i].addr;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("upload_din_%0d", i), 32'(ioctl_din), 32'(uv[i].din));
    end
    chk("upload_access", 32'(ram_access), 32'd1);
    ioctl_upload = 1'b0; ioctl_addr = 25'd0; tick();

    // Marker mismatch: periodic re-check, then insertion once the marker appears.
    setup_markers(8'h55);
    dl_scn1_tables(); dl_img(2, 20);
    bursts = 0; zrun = 0; gap_mon = 1'b1;
    dl_done();
    repeat (3 * (GAP + 6) + 30) @(negedge clk);
    gap_mon = 1'b0;
    chk("recheck_bursts_ge3", 32'(bursts >= 3), 32'd1);
    chk("recheck_gap_len", 32'(gap_seen), 32'(GAP));
    chk("no_insert_on_mismatch", 32'(hs_inserted), 32'd0);
    push_scn1(2);
    wb = wr_cnt;
    poke(10'h023, 8'h12);
    for (int n = 0; n < GAP + 12 && wr_cnt == wb; n++) begin @(negedge clk); #1; end
    chk("recheck_insert_started", 32'(wr_cnt != wb), 32'd1);
    wait_hs("scn2_inserted", 200);

    // Address wrap at the top of RAM.
    clear_ram();
    poke(10'h3FE, 8'hAA); poke(10'h001, 8'hBB);
    push_w(10'h3FE, img_b(3, 0)); push_w(10'h3FF, img_b(3, 1));
    push_w(10'h000, img_b(3, 2)); push_w(10'h001, img_b(3, 3));
    end_rd_seen = 1'b0;
    dl_rec(0, 32'h000003FE, 8'd4, 8'hAA, 8'hBB); dl_img(3, 4); dl_done();
    wait_hs("wrap_inserted", 200);
    chk("wrap_end_read", 32'(end_rd_seen), 32'd1);

    // Reset in the middle of WRITE.
    setup_markers(8'h12);
    push_scn1(4);
    dl_scn1_tables(); dl_img(4, 20);
    wb = wr_cnt;
    dl_done();
    for (int n = 0; n < 300 && (wr_cnt - wb) < 5; n++) begin @(negedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("five_writes_before_reset", 32'(wr_cnt - wb), 32'd5);
    chk("reset_we_low", 32'(ram_we), 32'd0);
    chk("reset_hs_low", 32'(hs_inserted), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    setup_markers(8'h12);
    wb = wr_cnt;
    dl_scn1_tables(); dl_done();
    repeat (150) @(negedge clk);
    chk("no_write_table_only", 32'(wr_cnt - wb), 32'd0);
    chk("no_hs_table_only", 32'(hs_inserted), 32'd0);
    push_scn1(5);
    dl_img(5, 20); dl_done();
    wait_hs("reinsert_after_reset", 400);

    // 17 records: the 17th must be dropped.
    clear_ram();
    for (int i = 0; i < 16; i++) push_w(10'h100 + 10'(2 * i), img_b(6, i));
    for (int i = 0; i < 16; i++) dl_rec(i, 32'(10'h100 + 10'(2 * i)), 8'd1, 8'h00, 8'h00);
    dl_rec(16, 32'h00000200, 8'd1, 8'h77, 8'h77);
    dl_img(6, 16); dl_done();
    wait_hs("entries_clamped_inserted", 600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
